// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter: shares one FIFO write port among NUM_REQ valid/ready
// producers, granting bursts of up to MAX_BURST beats and stalling on FIFO full.
module fifo_push_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_push_o,
  output logic [DATA_W-1:0]           fifo_push_data_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     own, own_nxt;
  logic [ID_W-1:0]     last, last_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  grant, grant_nxt;
  logic [ID_W-1:0]     grant_id, grant_id_nxt;

  logic [ID_W-1:0]     pick_all, pick_ex;
  logic                pick_all_vld, pick_ex_vld;
  logic                acc, end_cnt, end_drop;

  // Round-robin search from last+1; pick_ex skips last (the current owner in BURST).
  // Iterating backwards lets the earliest position in the search order win.
  always_comb begin
    int idx;
    idx          = 0;
    pick_all     = '0;
    pick_all_vld = 1'b0;
    pick_ex      = '0;
    pick_ex_vld  = 1'b0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = (int'(last) + i) % int'(NUM_REQ);
      if (req_valid_i[idx]) begin
        pick_all     = ID_W'(idx);
        pick_all_vld = 1'b1;
        if (i < int'(NUM_REQ)) begin
          pick_ex     = ID_W'(idx);
          pick_ex_vld = 1'b1;
        end
      end
    end
  end

  // Ready/push steering; data select depends only on own, never on data.
  always_comb begin
    req_ready_o      = '0;
    fifo_push_data_o = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      req_ready_o[k] = reset_n & (state == BURST) & (own == ID_W'(k)) & ~fifo_full_i;
      if (own == ID_W'(k)) begin
        fifo_push_data_o = req_data_i[k*int'(DATA_W) +: DATA_W];
      end
    end
  end

  assign acc         = req_valid_i[own] & req_ready_o[own];
  assign fifo_push_o = acc;
  assign end_cnt     = acc & (cnt == CNT_W'(MAX_BURST - 1));
  assign end_drop    = ~req_valid_i[own];

  // Next-state: burst bookkeeping and zero-bubble handover.
  always_comb begin
    state_nxt    = state;
    own_nxt      = own;
    last_nxt     = last;
    cnt_nxt      = cnt;
    grant_nxt    = '0;
    grant_id_nxt = '0;
    case (state)
      IDLE: begin
        if (pick_all_vld) begin
          state_nxt = BURST;
          own_nxt   = pick_all;
          last_nxt  = pick_all;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (acc) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (end_cnt) begin
          // Owner is valid here, so with no other requester it is re-granted.
          cnt_nxt = '0;
          if (pick_ex_vld) begin
            own_nxt  = pick_ex;
            last_nxt = pick_ex;
          end
        end else if (end_drop) begin
          cnt_nxt = '0;
          if (pick_all_vld) begin
            own_nxt  = pick_all;
            last_nxt = pick_all;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == BURST) begin
      grant_id_nxt = own_nxt;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        grant_nxt[k] = (own_nxt == ID_W'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      own      <= '0;
      last     <= ID_W'(NUM_REQ - 1);
      cnt      <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      own      <= own_nxt;
      last     <= last_nxt;
      cnt      <= cnt_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  assign grant_o    = grant;
  assign grant_id_o = grant_id;

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin push arbiter sharing one synchronous FIFO's write port among NUM_REQ producers. Each producer has a valid/ready interface. The arbiter grants ownership to one producer at a time for a burst of up to MAX_BURST beats. It steers the owner's data onto the FIFO push port and throttles on the FIFO full flag. It sits directly in front of the FIFO's push_i/push_data_i/full_o pins.

## Interface
- DATA_W, 8: data width per beat; matches the FIFO's DATA_W.
- NUM_REQ, 4: number of producers, ≥2.
- MAX_BURST, 4: maximum beats per grant, ≥1.
- ID_W, $clog2(NUM_REQ): localparam, width of the grant index.
- CNT_W, $clog2(MAX_BURST+1): localparam, width of the burst counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-producer beat valid.
- req_data_i  in  NUM_REQ*DATA_W  producer k data at bits [k*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  per-producer beat accept.
- fifo_full_i  in  1  FIFO full flag.
- fifo_push_o  out  1  FIFO push strobe.
- fifo_push_data_o  out  DATA_W  FIFO push data.
- grant_o  out  NUM_REQ  one-hot current owner; all-zero when idle.
- grant_id_o  out  ID_W  index of current owner; 0 when idle.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - BURST: owner register holds index `own`.
- Registered state:
  - state
  - own
  - last (round-robin pointer; last granted index)
  - cnt (beats accepted in the current burst, CNT_W bits)
- Round-robin pick: the first k with req_valid_i[k]=1, searching last+1, last+2, … mod NUM_REQ, ending at last itself.
- Combinational outputs:
  - req_ready_o[k] = reset_n & (state==BURST) & (own==k) & ~fifo_full_i.
  - Beat accepted: acc = req_valid_i[own] & req_ready_o[own].
  - fifo_push_o = acc.
  - fifo_push_data_o = req_data_i slice of own. Data is don't-care when fifo_push_o=0; drive the own slice anyway so there are no X.
- IDLE: if any req_valid_i is high → BURST. At the same edge: own=pick, last=pick, cnt=0. Otherwise stay in IDLE.
- BURST:
  - On acc: cnt+1.
  - End of burst: (acc & cnt==MAX_BURST-1) or req_valid_i[own]==0.
  - At end of burst, re-pick using the current-cycle valids:
    - Exclude own if the burst ended on cnt.
    - Include own, at lowest priority, if the burst ended on valid drop. In that case own is necessarily invalid, so it is never picked.
  - If a winner exists → stay in BURST with own=last=winner, cnt=0, back-to-back with no bubble.
  - If no winner: with MAX_BURST reached and only own valid → re-grant own, cnt=0. Otherwise → IDLE.
- fifo_full_i high: no beat accepted, cnt held, ownership held; full never ends a burst.
- Producers must hold data stable while valid and not ready. Dropping valid is legal and releases the grant.

## Timing
- Reset (reset_n low at a rising edge):
  - state=IDLE, own=0, last=NUM_REQ-1 (so producer 0 wins first), cnt=0.
  - Outputs: grant_o=0, grant_id_o=0, fifo_push_o=0, req_ready_o=0.
  - While reset_n is low, req_ready_o and fifo_push_o are forced 0 combinationally, so no beat is accepted in the reset cycle even from BURST.
- Arbitration latency from IDLE: valid seen in cycle N → grant_o valid in cycle N+1 → first beat accepted at the end of cycle N+1 if not full.
- Handover between owners: zero bubble cycles.
- One beat per cycle maximum. fifo_push_o and req_ready_o are combinational from state and from req_valid_i/fifo_full_i; there are no combinational paths from req_data_i to control.
- Full deasserted in cycle M → beat accepted at the end of cycle M.
- MAX_BURST=1: grant rotates after every beat.

## Test plan
- Reset then single producer: valid[2]=1 holding, full=0 → grant_o=0100 from cycle 1. Producer 2 gets 4 beats, then re-grant with no gap since it is the only requester. 8 beats in 9 cycles.
- All four valid continuously, MAX_BURST=4 → grant order 0,1,2,3,0. Each owner gets exactly 4 fifo_push_o pulses, no idle cycles between bursts. FIFO contents are in grant order.
- Full stall: owner 1 at cnt=2, fifo_full_i high for 3 cycles → req_ready_o=0, fifo_push_o=0, cnt stays 2. Burst completes its remaining 2 beats after full drops.
- Early release: owner 0 drops valid after 1 beat while valid[3]=1 → grant moves to 3 at the next edge. Producer 0 is next visited only after 3 (order 1, 2, 3, 0).
- Mid-burst reset: reset_n low during BURST with valid high → fifo_push_o=0 in that cycle. After the edge: grant_o=0, state IDLE, next grant goes to the lowest valid index.
- Equal service under saturation with FIFO full toggling every other cycle over 1000 cycles → per-producer beat counts differ by ≤ MAX_BURST. No beat is pushed while fifo_full_i=1.
